// File: rtl/fetch_sequencer.sv
// Program-counter and fetch sequencer with a req/done run handshake, stall,
// and a hardware call/return stack. All outputs are registered.
module fetch_sequencer #(
  parameter int PW         = 12,
  parameter int SD         = 4,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 128,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          jump_en,
  input  logic          branch_en,
  input  logic          zero,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic [PW-1:0] target,
  output logic [PW-1:0] prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic          stack_err,
  output logic [CW-1:0] cycle_cnt
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [PW-1:0]  START_L = PW'(START_ADDR);
  localparam logic [PW-1:0]  END_L   = PW'(END_ADDR);
  localparam logic [SPW-1:0] FULL_L  = SPW'(SD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  pc_q, pc_d;
  logic           fv_q, fv_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [PW-1:0]  stack_q [SD];

  logic [PW-1:0]  pc_inc_s;
  logic [PW-1:0]  npc_s;
  logic [SPW-1:0] sp_m1_s;
  logic           push_s;
  logic           pop_s;
  logic           abort_s;
  logic           err_set_s;
  logic           end_hit_s;
  logic           stack_we_s;

  // Next-PC selection and stack bookkeeping for a non-stalled RUN cycle
  always_comb begin
    pc_inc_s  = pc_q + PW'(1);
    sp_m1_s   = sp_q - SPW'(1);
    npc_s     = pc_inc_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    abort_s   = 1'b0;
    err_set_s = 1'b0;
    if (ret_en) begin
      if (sp_q != '0) begin
        npc_s = stack_q[sp_m1_s[IW-1:0]];
        pop_s = 1'b1;
      end else begin
        // Underflow ends the run with the PC left where it was.
        npc_s     = pc_q;
        abort_s   = 1'b1;
        err_set_s = 1'b1;
      end
    end else if (call_en) begin
      npc_s = target;
      if (sp_q != FULL_L) begin
        push_s = 1'b1;
      end else begin
        err_set_s = 1'b1;
      end
    end else if (jump_en) begin
      npc_s = target;
    end else if (branch_en && zero) begin
      npc_s = target;
    end else begin
      npc_s = pc_inc_s;
    end
    end_hit_s = (npc_s == END_L) && !abort_s;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_RUN;
        else     state_d = S_IDLE;
      end
      S_RUN: begin
        if (!stall && (abort_s || end_hit_s)) state_d = S_DONE;
        else                                  state_d = S_RUN;
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
        else      state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and stack pointer
  always_comb begin
    pc_d       = pc_q;
    fv_d       = fv_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sp_d       = sp_q;
    stack_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d   = START_L;
        done_d = 1'b0;
        if (req) begin
          fv_d  = 1'b1;
          cnt_d = '0;
          err_d = 1'b0;
          sp_d  = '0;
        end else begin
          fv_d = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        else             cnt_d = cnt_q;
        if (!stall) begin
          if (err_set_s) err_d = 1'b1;
          else           err_d = err_q;
          if (push_s) begin
            sp_d       = sp_q + SPW'(1);
            stack_we_s = 1'b1;
          end else if (pop_s) begin
            sp_d = sp_m1_s;
          end else begin
            sp_d = sp_q;
          end
          if (abort_s) begin
            fv_d   = 1'b0;
            done_d = 1'b1;
          end else begin
            pc_d = npc_s;
            if (end_hit_s) begin
              fv_d   = 1'b0;
              done_d = 1'b1;
            end else begin
              fv_d   = 1'b1;
              done_d = 1'b0;
            end
          end
        end else begin
          pc_d = pc_q;
          sp_d = sp_q;
        end
      end
      S_DONE: begin
        fv_d = 1'b0;
        if (!req) begin
          done_d = 1'b0;
          pc_d   = START_L;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        pc_d   = START_L;
        fv_d   = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        cnt_d  = '0;
        sp_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_L;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
    end
  end

  // Return-address storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SD; i++) stack_q[i] <= '0;
    end else if (stack_we_s) begin
      stack_q[sp_q[IW-1:0]] <= pc_inc_s;
    end
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = fv_q;
  assign done        = done_q;
  assign stack_err   = err_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer at default parameters.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, stall, jump_en, branch_en, zero, call_en, ret_en;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        fetch_valid, done, stack_err;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .jump_en(jump_en),
    .branch_en(branch_en), .zero(zero), .call_en(call_en), .ret_en(ret_en),
    .target(target), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
    .done(done), .stack_err(stack_err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0; zero = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; target = 12'd0;
  endtask

  task automatic status(input string tag, input logic [11:0] pc, input logic fv,
                        input logic dn, input logic er);
    chk({tag, ".pc"}, {20'd0, prog_ctr}, {20'd0, pc});
    chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, fv});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    chk({tag, ".err"}, {31'd0, stack_err}, {31'd0, er});
  endtask

  initial begin
    reset = 1'b0; req = 1'b0;
    clr();
    #13;
    status("rst", 12'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", {16'd0, cycle_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    status("idle", 12'd0, 1'b0, 1'b0, 1'b0);

    // Straight-line run to END_ADDR, dropping req halfway
    req = 1'b1;
    step();
    status("start", 12'd0, 1'b1, 1'b0, 1'b0);
    chk("start.cnt", {16'd0, cycle_cnt}, 32'd0);
    for (int i = 1; i < 128; i++) begin
      if (i == 64) req = 1'b0;
      step();
      chk("seq.pc", {20'd0, prog_ctr}, i);
    end
    chk("seq.cnt127", {16'd0, cycle_cnt}, 32'd127);
    step();
    status("end", 12'd128, 1'b0, 1'b1, 1'b0);
    chk("end.cnt", {16'd0, cycle_cnt}, 32'd128);
    step();
    status("back_idle", 12'd0, 1'b0, 1'b0, 1'b0);

    // Call/return, branch and priority
    req = 1'b1;
    step();
    jump_en = 1'b1; target = 12'd5;
    step();
    chk("jump5", {20'd0, prog_ctr}, 32'd5);
    clr(); call_en = 1'b1; target = 12'd40;
    step();
    chk("call40", {20'd0, prog_ctr}, 32'd40);
    clr();
    step();
    chk("inc41", {20'd0, prog_ctr}, 32'd41);
    ret_en = 1'b1;
    step();
    status("ret6", 12'd6, 1'b1, 1'b0, 1'b0);
    clr(); jump_en = 1'b1; target = 12'd3;
    step();
    clr(); branch_en = 1'b1; target = 12'd20; zero = 1'b0;
    step();
    chk("br_not", {20'd0, prog_ctr}, 32'd4);
    clr(); jump_en = 1'b1; target = 12'd3;
    step();
    clr(); branch_en = 1'b1; target = 12'd20; zero = 1'b1;
    step();
    chk("br_taken", {20'd0, prog_ctr}, 32'd20);
    clr(); call_en = 1'b1; target = 12'd50;
    step();
    clr(); jump_en = 1'b1; ret_en = 1'b1; target = 12'd99;
    step();
    status("ret_wins", 12'd21, 1'b1, 1'b0, 1'b0);
    clr(); jump_en = 1'b1; target = 12'd128;
    step();
    status("jump_end", 12'd128, 1'b0, 1'b1, 1'b0);
    chk("jump_end.cnt", {16'd0, cycle_cnt}, 32'd11);
    clr();
    for (int i = 0; i < 3; i++) begin
      step();
      status("done_hold", 12'd128, 1'b0, 1'b1, 1'b0);
    end
    chk("done_hold.cnt", {16'd0, cycle_cnt}, 32'd11);
    req = 1'b0;
    step();
    status("done_exit", 12'd0, 1'b0, 1'b0, 1'b0);

    // Overflow on the fifth nested call, then unwind to underflow
    req = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      clr(); call_en = 1'b1; target = 12'(10 * i);
      step();
      chk("nest.pc", {20'd0, prog_ctr}, 10 * i);
    end
    chk("nest.err", {31'd0, stack_err}, 32'd0);
    call_en = 1'b1; target = 12'd50;
    step();
    status("ovf", 12'd50, 1'b1, 1'b0, 1'b1);
    clr(); ret_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("unwind.pc", {20'd0, prog_ctr}, 10 * i + 1);
    end
    step();
    status("unf", 12'd1, 1'b0, 1'b1, 1'b1);
    clr(); req = 1'b0;
    step();
    chk("idle_err_held", {31'd0, stack_err}, 32'd1);
    req = 1'b1;
    step();
    status("fresh", 12'd0, 1'b1, 1'b0, 1'b0);
    ret_en = 1'b1;
    step();
    status("fresh_unf", 12'd0, 1'b0, 1'b1, 1'b1);
    chk("fresh_unf.cnt", {16'd0, cycle_cnt}, 32'd1);
    clr(); req = 1'b0;
    step();

    // Stall, PC wrap, then asynchronous reset mid-run
    req = 1'b1;
    step();
    jump_en = 1'b1; target = 12'd10;
    step();
    chk("st.pc", {20'd0, prog_ctr}, 32'd10);
    stall = 1'b1; target = 12'd77; ret_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("stall.pc", {20'd0, prog_ctr}, 32'd10);
      chk("stall.cnt", {16'd0, cycle_cnt}, 1 + i);
    end
    clr();
    step();
    chk("unstall.pc", {20'd0, prog_ctr}, 32'd11);
    chk("unstall.cnt", {16'd0, cycle_cnt}, 32'd5);
    jump_en = 1'b1; target = 12'd4095;
    step();
    clr();
    step();
    chk("wrap", {20'd0, prog_ctr}, 32'd0);
    jump_en = 1'b1; target = 12'd57;
    step();
    clr();
    chk("pre_rst", {20'd0, prog_ctr}, 32'd57);
    #2;
    reset = 1'b0;
    #1;
    status("async_rst", 12'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.cnt", {16'd0, cycle_cnt}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    status("post_rst", 12'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised program-counter and fetch sequencer. Successor to the fixed-width PC, jump-LUT and "done at address 128" logic of the current core.
- Adds a req/done run handshake, stall, and a hardware call/return stack.
- Sits between the control decoder and the instruction ROM: drives the ROM address and reports run status to the testbench or host.

Parameters:
- PW, 12, program-counter width in bits.
- SD, 4, return-stack depth in entries (at least 1).
- START_ADDR, 0, PC loaded on each run start.
- END_ADDR, 128, PC value that terminates a run.
- CW, 16, cycle-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  run request, level-sensitive.
- stall  in  1  hold PC and all state this cycle (RUN only).
- jump_en  in  1  unconditional jump to target.
- branch_en  in  1  conditional branch to target.
- zero  in  1  ALU zero flag; the branch is taken when zero=1.
- call_en  in  1  jump to target and push prog_ctr+1.
- ret_en  in  1  pop the stack into the PC.
- target  in  PW  jump/branch/call destination (from the LUT).
- prog_ctr  out  PW  current fetch address.
- fetch_valid  out  1  prog_ctr is a live fetch this cycle.
- done  out  1  run complete.
- stack_err  out  1  sticky stack overflow or underflow.
- cycle_cnt  out  CW  clock cycles spent in RUN.

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (asynchronous, low), taking effect immediately and regardless of state:
  - state=IDLE, prog_ctr=START_ADDR.
  - fetch_valid=0, done=0, stack_err=0, cycle_cnt=0.
  - Stack pointer=0 (stack empty).
- IDLE:
  - prog_ctr holds START_ADDR and all control inputs are ignored.
  - req=1 → next cycle state=RUN, fetch_valid=1, prog_ctr=START_ADDR.
  - On that same edge: cycle_cnt=0, stack_err=0, stack emptied.
- RUN, fetch_valid=1:
  - cycle_cnt increments every RUN cycle, including stalled cycles, and saturates at all-ones.
  - stall=1 → prog_ctr and the stack hold and all control inputs are ignored.
  - Otherwise next PC follows this priority: ret_en > call_en > jump_en > (branch_en & zero) > prog_ctr+1.
  - ret_en with stack non-empty → PC = top entry, pop.
  - ret_en with stack empty → stack_err=1, abort directly to DONE with prog_ctr held.
  - call_en with stack not full → push prog_ctr+1 (mod 2^PW), PC=target.
  - call_en with stack full → no push, stack_err=1, PC=target, run continues.
  - prog_ctr+1 wraps 2^PW-1 → 0.
  - If the computed next PC equals END_ADDR, the same edge loads prog_ctr=END_ADDR, state=DONE, done=1, fetch_valid=0.
  - req dropping during RUN is ignored; the run continues.
- DONE:
  - done=1, fetch_valid=0; prog_ctr, cycle_cnt and stack_err hold.
  - req=0 → next cycle IDLE, done=0, prog_ctr=START_ADDR.
  - req held high keeps DONE; there is no automatic restart.
- Unused low-priority controls in a cycle are dropped. Stack contents are not readable externally.

Test Plan:
- Reset then req=1 with no controls; END_ADDR=128 → prog_ctr steps 0,1,…,127; done=1 on the edge PC reaches 128; cycle_cnt=128.
- PC=5, call_en=1, target=40; then at PC=41, ret_en=1 → PC 5→40→41→6; stack_err=0.
- branch_en=1, target=20 at PC=3: zero=0 → PC=4; zero=1 → PC=20. jump_en and ret_en both high on a non-empty stack → ret wins.
- SD=4: five nested calls → stack_err=1 after the fifth, PC=target. Ret on an empty stack in a fresh run → stack_err=1, DONE, done=1.
- stall=1 for 3 cycles at PC=10 → prog_ctr stays 10 and cycle_cnt advances by 3. req dropped mid-run → run still completes.
- Assert reset low mid-RUN at PC=57 → outputs go to reset values immediately. DONE with req held high → stays DONE; req low → IDLE and PC=0 on the next cycle.
